ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
- Pipeline control for the 5-stage RV32I core.
- Sequences the EX-stage datapath, including the I-type ALU: generates PC/IF-ID stalls, ID/EX bubbles, IF/ID flushes, and registered operand-forwarding selects.
- Keeps a shadow copy of the EX, MEM and WB slots (valid, rd, regwrite, is_load), so hazards are resolved from its own state rather than from pipeline-register taps.
- Sits beside the ID/EX pipeline register; its outputs drive stage enables and EX operand muxes.

Parameters:
REG_AW, 5, register-address width
CNT_W, 16, width of saturating performance counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_AW  ID source 1 address
id_rs2  in  REG_AW  ID source 2 address
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2 (0 for I-type)
id_rd  in  REG_AW  ID destination
id_regwrite  in  1  ID writes rd
id_is_load  in  1  ID is a load
ex_branch_taken  in  1  EX redirects PC this cycle
mem_stall  in  1  data memory wait; freeze whole pipe
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID register
flush_if_id  out  1  zero IF/ID register
bubble_id_ex  out  1  load NOP into ID/EX
fwd_a  out  2  EX operand A select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
fwd_b  out  2  EX operand B select, same encoding
load_use_cnt  out  CNT_W  load-use stall cycles, saturating
flush_cnt  out  CNT_W  branch flushes, saturating

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. During reset, all shadow slots are invalid, fwd_a/fwd_b = 00, and both counters = 0. With id_valid=0, all stall, flush and bubble outputs are 0.
- Match rule: a slot S matches source r when S.valid & S.regwrite & S.rd==r & r!=0 & the matching use bit is set. x0 never matches.
- Load-use: asserted when id_valid and EX slot is_load matches rs1 or rs2. Effect: stall_pc=stall_if_id=1, bubble_id_ex=1, for exactly one cycle.
- Branch: when ex_branch_taken=1, flush_if_id=1 and bubble_id_ex=1; stall_pc=0 and stall_if_id=0. Branch overrides load-use in the same cycle, and load_use_cnt does not increment.
- mem_stall=1:
  - stall_pc=stall_if_id=1, flush_if_id=0, bubble_id_ex=0.
  - Shadow slots, fwd_a/fwd_b and counters are held.
  - ex_branch_taken is ignored; EX holds it until the stall releases.
- Advance (every clk edge with mem_stall=0):
  - WB <= MEM, MEM <= EX.
  - EX <= ID fields if id_valid & !bubble_id_ex; otherwise EX <= invalid.
- Forward selects are computed in ID and registered on advance, so they are valid while the instruction sits in EX (1-cycle latency).
  - Operand A: 01 if the current EX slot (non-load) matches rs1; else 10 if the current MEM slot matches rs1; else 00.
  - Operand B: same rule applied to rs2.
  - EX has priority over MEM.
  - The WB slot is never forwarded: the regfile provides write-through bypass.
  - On a bubble, registered fwd = 00.
- Counters:
  - load_use_cnt +1 per load-use stall cycle.
  - flush_cnt +1 per accepted ex_branch_taken.
  - Both hold at all-ones.
- Reset mid-stall: outputs drop immediately (async). The first cycle after reset has no hazard history.

Decomposition:
- Shared package riscv_pkg gets:
  - fwd_sel_e enum (FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10);
  - struct slot_t {valid, rd, regwrite, is_load};
  - constant REG_X0.
- Sub-module fwd_sel_unit: combinational, one instance per operand. Inputs: source address, use bit, EX slot, MEM slot. Output: fwd_sel_e.

Test Plan:
- Reset: rst_n=0 with id_valid=1 → all outputs 0, counters 0; release → no stall on first instruction.
- Load-use: lw x5 in EX, then addi x6,x5,1 in ID → one cycle of stall_pc=stall_if_id=bubble_id_ex=1, load_use_cnt=1. Next cycle the addi enters EX with fwd_a=10.
- ALU chain: addi x1,x0,3; addi x2,x1,4 → fwd_a=01. Then slli x3,x1,2 two instructions after x1 → fwd_a=10. Target rd=x0 never forwarded (fwd_a=00).
- Branch priority: ex_branch_taken=1 while load-use pending → flush_if_id=1, bubble_id_ex=1, stall_pc=0, flush_cnt=1, load_use_cnt unchanged.
- mem_stall=1 for 3 cycles mid-chain → shadow and fwd frozen, branch ignored. Release → forwarding resumes with identical selects.
- Counter saturation: force 2^16+5 flushes → flush_cnt = 16'hFFFF.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared pipeline types for the RV32I core: forwarding selects, shadow slot
// layout and the hard-wired zero register address.
package riscv_pkg;

  localparam int SLOT_AW = 5;
  localparam logic [SLOT_AW-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rd;
    logic               regwrite;
    logic               is_load;
  } slot_t;

  // A slot produces source r only if it really writes a non-zero rd and the reader uses r.
  function automatic logic slot_match(slot_t s, logic [SLOT_AW-1:0] r, logic use_bit);
    return s.valid & s.regwrite & (s.rd == r) & (r != REG_X0) & use_bit;
  endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Bundle between the ID/EX pipeline glue (master) and the hazard controller (slave).
// Handshake: none -- every input is sampled each clk edge, and mem_stall is the only flow control.
interface ex_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  import riscv_pkg::*;

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_is_load;
  logic              ex_branch_taken;
  logic              mem_stall;
  logic              stall_pc;
  logic              stall_if_id;
  logic              flush_if_id;
  logic              bubble_id_ex;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [CNT_W-1:0]  load_use_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  slot_t             dbg_wb;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_is_load, ex_branch_taken, mem_stall,
    input  stall_pc, stall_if_id, flush_if_id, bubble_id_ex, fwd_a, fwd_b,
           load_use_cnt, flush_cnt, dbg_wb
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_is_load, ex_branch_taken, mem_stall,
    output stall_pc, stall_if_id, flush_if_id, bubble_id_ex, fwd_a, fwd_b,
           load_use_cnt, flush_cnt, dbg_wb
  );

endinterface

// File: rtl/fwd_sel_unit.sv
// Operand forwarding select for one EX source, computed while the instruction is in ID.
module fwd_sel_unit
  import riscv_pkg::*;
(
  input  logic [SLOT_AW-1:0] i_rs,
  input  logic               i_use,
  input  slot_t              i_ex,
  input  slot_t              i_mem,
  output fwd_sel_e           o_sel
);

  logic w_ex_hit;
  logic w_mem_hit;

  // A load in EX has no result yet; that case is a load-use stall, not a forward.
  assign w_ex_hit  = slot_match(i_ex, i_rs, i_use) & ~i_ex.is_load;
  assign w_mem_hit = slot_match(i_mem, i_rs, i_use);

  always_comb begin
    o_sel = FWD_RF;
    if (w_ex_hit)       o_sel = FWD_EXMEM;
    else if (w_mem_hit) o_sel = FWD_MEMWB;
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard control: shadows EX/MEM/WB slots, raises stalls, bubbles and
// flushes, and registers operand forwarding selects for the next EX instruction.
module ex_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             rst_n,
  ex_hazard_ctrl_if.slave bus
);

  slot_t            r_ex;
  slot_t            r_mem;
  slot_t            r_wb;
  fwd_sel_e         r_fwd_a;
  fwd_sel_e         r_fwd_b;
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_fl_cnt;

  slot_t    w_id_slot;
  fwd_sel_e w_sel_a;
  fwd_sel_e w_sel_b;
  logic     w_load_use;
  logic     w_branch;
  logic     w_lu_inc;
  logic     w_stall;
  logic     w_flush;
  logic     w_bubble;

  assign w_id_slot = '{valid:    bus.id_valid,
                       rd:       bus.id_rd,
                       regwrite: bus.id_regwrite,
                       is_load:  bus.id_is_load};

  assign w_load_use = bus.id_valid & r_ex.is_load &
                      (slot_match(r_ex, bus.id_rs1, bus.id_use_rs1) |
                       slot_match(r_ex, bus.id_rs2, bus.id_use_rs2));

  // A taken branch is only accepted once the memory stall lets EX move on.
  assign w_branch = bus.ex_branch_taken & ~bus.mem_stall;
  assign w_lu_inc = w_load_use & ~bus.ex_branch_taken & ~bus.mem_stall;

  always_comb begin
    w_stall  = 1'b0;
    w_flush  = 1'b0;
    w_bubble = 1'b0;
    if (rst_n && bus.id_valid) begin
      if (bus.mem_stall) begin
        w_stall = 1'b1;
      end else if (w_branch) begin
        w_flush  = 1'b1;
        w_bubble = 1'b1;
      end else if (w_load_use) begin
        w_stall  = 1'b1;
        w_bubble = 1'b1;
      end
    end
  end

  fwd_sel_unit u_fwd_a (
    .i_rs  (bus.id_rs1),
    .i_use (bus.id_use_rs1),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .o_sel (w_sel_a)
  );

  fwd_sel_unit u_fwd_b (
    .i_rs  (bus.id_rs2),
    .i_use (bus.id_use_rs2),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .o_sel (w_sel_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex     <= '0;
      r_mem    <= '0;
      r_wb     <= '0;
      r_fwd_a  <= FWD_RF;
      r_fwd_b  <= FWD_RF;
      r_lu_cnt <= '0;
      r_fl_cnt <= '0;
    end else if (!bus.mem_stall) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (bus.id_valid && !w_bubble) begin
        r_ex    <= w_id_slot;
        r_fwd_a <= w_sel_a;
        r_fwd_b <= w_sel_b;
      end else begin
        r_ex    <= '0;
        r_fwd_a <= FWD_RF;
        r_fwd_b <= FWD_RF;
      end
      if (w_lu_inc && (r_lu_cnt != '1)) r_lu_cnt <= r_lu_cnt + CNT_W'(1);
      if (w_branch && (r_fl_cnt != '1)) r_fl_cnt <= r_fl_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_pc     = w_stall;
  assign bus.stall_if_id  = w_stall;
  assign bus.flush_if_id  = w_flush;
  assign bus.bubble_id_ex = w_bubble;
  assign bus.fwd_a        = r_fwd_a;
  assign bus.fwd_b        = r_fwd_b;
  assign bus.load_use_cnt = r_lu_cnt;
  assign bus.flush_cnt    = r_fl_cnt;
  assign bus.dbg_wb       = r_wb;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed pipeline scenarios plus random traffic,
// checked against a slot-array reference model of the hazard rules.
module tb_ex_hazard_ctrl;
  import riscv_pkg::*;

  localparam int AW = 5;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

  ex_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  // index 0 = EX, 1 = MEM, 2 = WB
  bit       m_v [3];
  int       m_rd[3];
  bit       m_rw[3];
  bit       m_ld[3];
  int       m_lu, m_fl;
  logic [3:0] exp_q[$];   // registered {fwd_a, fwd_b} currently expected in EX

  bit d_v, d_u1, d_u2, d_rw, d_ld, d_br, d_ms;
  int d_rs1, d_rs2, d_rd;
  bit e_stall, e_flush, e_bubble, e_lu;

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit hit(int k, int r, bit u);
    return m_v[k] && m_rw[k] && (m_rd[k] == r) && (r != 0) && u;
  endfunction

  function automatic logic [1:0] sel(int r, bit u);
    if (hit(0, r, u) && !m_ld[0]) return 2'd1;
    if (hit(1, r, u))             return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_v[k] = 0; m_rd[k] = 0; m_rw[k] = 0; m_ld[k] = 0;
    end
    m_lu = 0; m_fl = 0;
    exp_q.delete();
    exp_q.push_back(4'd0);
  endtask

  task automatic model_eval();
    e_lu = d_v && m_ld[0] && (hit(0, d_rs1, d_u1) || hit(0, d_rs2, d_u2));
    e_stall = 0; e_flush = 0; e_bubble = 0;
    if (d_v) begin
      if (d_ms)      e_stall = 1;
      else if (d_br) begin e_flush = 1; e_bubble = 1; end
      else if (e_lu) begin e_stall = 1; e_bubble = 1; end
    end
  endtask

  task automatic model_adv();
    logic [3:0] nf;
    model_eval();
    if (d_ms) return;
    if (e_lu && !d_br && m_lu < CNT_MAX) m_lu++;
    if (d_br && m_fl < CNT_MAX) m_fl++;
    nf = (d_v && !e_bubble) ? {sel(d_rs1, d_u1), sel(d_rs2, d_u2)} : 4'd0;
    void'(exp_q.pop_front());
    exp_q.push_back(nf);
    for (int k = 2; k > 0; k--) begin
      m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_rw[k] = m_rw[k-1]; m_ld[k] = m_ld[k-1];
    end
    m_v[0]  = d_v && !e_bubble;
    m_rd[0] = d_rd; m_rw[0] = d_rw; m_ld[0] = d_ld;
  endtask

  task automatic model_check();
    model_eval();
    check("stall_pc",     bus.stall_pc,     e_stall);
    check("stall_if_id",  bus.stall_if_id,  e_stall);
    check("flush_if_id",  bus.flush_if_id,  e_flush);
    check("bubble_id_ex", bus.bubble_id_ex, e_bubble);
    check("fwd_a",        bus.fwd_a,        exp_q[0][3:2]);
    check("fwd_b",        bus.fwd_b,        exp_q[0][1:0]);
    check("load_use_cnt", bus.load_use_cnt, m_lu);
    check("flush_cnt",    bus.flush_cnt,    m_fl);
    check("wb_valid",     bus.dbg_wb.valid, m_v[2]);
    if (m_v[2]) check("wb_rd", bus.dbg_wb.rd, m_rd[2]);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit rw, input bit ld, input bit br, input bit ms);
    d_v = v; d_rs1 = rs1; d_u1 = u1; d_rs2 = rs2; d_u2 = u2;
    d_rd = rd; d_rw = rw; d_ld = ld; d_br = br; d_ms = ms;
    bus.id_valid = v;            bus.id_rs1 = AW'(rs1);   bus.id_rs2 = AW'(rs2);
    bus.id_use_rs1 = u1;         bus.id_use_rs2 = u2;     bus.id_rd = AW'(rd);
    bus.id_regwrite = rw;        bus.id_is_load = ld;
    bus.ex_branch_taken = br;    bus.mem_stall = ms;
  endtask

  // One cycle: drive at negedge, check mid-cycle, advance model, end just after posedge.
  task automatic step(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit rw, input bit ld, input bit br, input bit ms);
    @(negedge clk);
    drive(v, rs1, u1, rs2, u2, rd, rw, ld, br, ms);
    #1;
    model_check();
    model_adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1, 1, 1, 2, 1, 3, 1, 1, 1, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive(1, 5, 1, 5, 1, 5, 1, 1, 0, 1);
    model_reset();
    #1;
    check("rst_stall_pc", bus.stall_pc, 0);
    check("rst_flush",    bus.flush_if_id, 0);
    check("rst_bubble",   bus.bubble_id_ex, 0);
    check("rst_fwd_a",    bus.fwd_a, 0);
    check("rst_lu_cnt",   bus.load_use_cnt, 0);
    check("rst_fl_cnt",   bus.flush_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // load-use: lw x5 ; addi x6,x5,1 (held one cycle by the stall)
    step(1, 1, 1, 0, 0, 5, 1, 1, 0, 0);
    step(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
    check("lu_cnt_after_stall", bus.load_use_cnt, 1);
    step(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
    check("lu_fwd_memwb", bus.fwd_a, 2);

    // ALU chain: x1 -> x2 (EX fwd) -> x3 (MEM fwd) -> x0 writes never forward
    step(1, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 2, 1, 0, 0, 0);
    check("chain_fwd_exmem", bus.fwd_a, 1);
    step(1, 1, 1, 0, 0, 3, 1, 0, 0, 0);
    check("chain_fwd_memwb", bus.fwd_a, 2);
    step(1, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1, 4, 1, 0, 0, 0);
    check("x0_fwd_a", bus.fwd_a, 0);
    check("x0_fwd_b", bus.fwd_b, 0);

    // branch taken while a load-use is pending
    step(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    step(1, 7, 1, 0, 0, 8, 1, 0, 1, 0);
    check("br_lu_cnt_held", bus.load_use_cnt, 1);
    check("br_flush_cnt",   bus.flush_cnt, 1);

    // mem_stall for 3 cycles mid-chain with a branch that must be ignored
    step(1, 0, 1, 0, 0, 8, 1, 0, 0, 0);
    step(1, 8, 1, 0, 0, 9, 1, 0, 0, 0);
    check("pre_stall_fwd_a", bus.fwd_a, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 9, 1, 0, 0, 10, 1, 0, 1, 1);
      check("frozen_fwd_a", bus.fwd_a, 1);
      check("frozen_fl_cnt", bus.flush_cnt, 1);
    end
    step(1, 9, 1, 0, 0, 10, 1, 0, 0, 0);
    check("resume_fwd_a", bus.fwd_a, 1);

    // randomized traffic with occasional asynchronous reset during a stall
    for (int i = 0; i < 1500; i++) begin
      if (i % 500 == 250) begin
        drive(1, 1, 1, 1, 1, 1, 1, 1, 0, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_stall_pc", bus.stall_pc, 0);
        check("async_fwd_a",    bus.fwd_a, 0);
        check("async_lu_cnt",   bus.load_use_cnt, 0);
        check("async_fl_cnt",   bus.flush_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      step($urandom_range(0, 99) < 85,
           $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 99) < 80,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 15);
    end

    // flush counter saturation
    do_reset();
    for (int i = 0; i < (1 << CW) + 5; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      model_adv();
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("flush_cnt_sat", bus.flush_cnt, 16'hFFFF);
    model_check();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
